// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths, request record and the
// round-robin pick used by the two-master memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // One captured master request at the default widths.
    typedef struct packed {
        logic                  rw;
        logic [ADDR_W_DEF-1:0] addr;
        logic [LINE_W_DEF-1:0] data;
    } req_t;

    // A lone requester wins outright; a tie goes to the master not served last.
    function automatic logic pick_winner(input logic [1:0] pend, input logic last_grant);
        logic winner;
        if (pend == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = pend[1];
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_arb_req_buf.sv
// mem_arb_req_buf: per-master request capture. Holds the latched request,
// the pending flag (a new pulse beats a same-cycle clear) and a sticky
// overrun flag for pulses that arrive while a request is still outstanding.
module mem_arb_req_buf
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_data,
    input  logic              pend_clr,
    output logic              pend,
    output logic              buf_rw,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [LINE_W-1:0] buf_data,
    output logic              overrun
);

    logic accept;
    logic drop;

    // A pulse is taken when the slot is free or is being retired this cycle.
    assign accept = req_valid && (!pend || pend_clr);
    assign drop   = req_valid && pend && !pend_clr;

    // Latch the request fields only when the pulse is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_rw   <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (accept) begin
            buf_rw   <= req_rw;
            buf_addr <= req_addr;
            buf_data <= req_data;
        end
    end

    // Pending flag: set wins over clear so back-to-back requests survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (accept) begin
            pend <= 1'b1;
        end else if (pend_clr) begin
            pend <= 1'b0;
        end
    end

    // Sticky overrun: a dropped pulse is remembered until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pulse-protocol memory port between two cache
// controllers. Requests are captured per master, serialized round-robin,
// and completions plus read data are routed back to the owning master.
// Every output comes straight from a flop.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_req_valid,
    input  logic [1:0]          m_req_rw,
    input  logic [2*ADDR_W-1:0] m_req_addr,
    input  logic [2*LINE_W-1:0] m_req_dataout,
    output logic [1:0]          m_req_ready,
    output logic [LINE_W-1:0]   m_req_datain,
    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [LINE_W-1:0]   mem_req_dataout,
    input  logic [LINE_W-1:0]   mem_req_datain,
    input  logic                mem_req_ready,
    output logic                grant_id,
    output logic                busy,
    output logic [1:0]          overrun_err
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              winner;
    logic              last_grant;
    logic [1:0]        pend;
    logic [1:0]        pend_clr;
    logic [1:0]        buf_rw;
    logic [ADDR_W-1:0] buf_addr [2];
    logic [LINE_W-1:0] buf_data [2];

    for (genvar i = 0; i < 2; i++) begin : g_buf
        mem_arb_req_buf #(
            .ADDR_W (ADDR_W),
            .LINE_W (LINE_W)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .req_valid (m_req_valid[i]),
            .req_rw    (m_req_rw[i]),
            .req_addr  (m_req_addr[i*ADDR_W +: ADDR_W]),
            .req_data  (m_req_dataout[i*LINE_W +: LINE_W]),
            .pend_clr  (pend_clr[i]),
            .pend      (pend[i]),
            .buf_rw    (buf_rw[i]),
            .buf_addr  (buf_addr[i]),
            .buf_data  (buf_data[i]),
            .overrun   (overrun_err[i])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and winner selection; stray completions outside WAIT are ignored.
    always_comb begin
        state_next = state;
        winner     = grant_id;
        case (state)
            IDLE: begin
                if (pend != 2'b00) begin
                    winner     = pick_winner(pend, last_grant);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_req_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The owner's pending flag is retired during its response cycle.
    always_comb begin
        pend_clr = 2'b00;
        if (state == RESP) begin
            pend_clr[grant_id] = 1'b1;
        end
    end

    // Ownership: record the winner on issue and the served master on retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && state_next == ISSUE) begin
                grant_id <= winner;
            end
            if (state == RESP) begin
                last_grant <= grant_id;
            end
        end
    end

    // Memory request: one-cycle pulse, fields loaded on issue and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_valid   <= 1'b0;
            mem_req_rw      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_dataout <= '0;
        end else begin
            mem_req_valid <= (state_next == ISSUE);
            if (state_next == ISSUE) begin
                mem_req_rw      <= buf_rw[winner];
                mem_req_addr    <= buf_addr[winner];
                mem_req_dataout <= buf_data[winner];
            end
        end
    end

    // Response: capture the returned line (it doubles as the held read-data register) and pulse the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_datain <= '0;
            m_req_ready  <= 2'b00;
        end else begin
            if (state == WAIT && mem_req_ready) begin
                m_req_datain <= mem_req_datain;
            end
            m_req_ready <= (state_next == RESP) ? (2'b01 << grant_id) : 2'b00;
        end
    end

    // Busy mirrors "not idle", registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a timestamp-based transaction model of the arbiter.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          m_req_valid;
    logic [1:0]          m_req_rw;
    logic [2*ADDR_W-1:0] m_req_addr;
    logic [2*LINE_W-1:0] m_req_dataout;
    logic [1:0]          m_req_ready;
    logic [LINE_W-1:0]   m_req_datain;
    logic                mem_req_valid;
    logic                mem_req_rw;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [LINE_W-1:0]   mem_req_dataout;
    logic [LINE_W-1:0]   mem_req_datain;
    logic                mem_req_ready;
    logic                grant_id;
    logic                busy;
    logic [1:0]          overrun_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int mem_cnt  = 0;
    logic rr_exp = 1'b0;

    // Reference model: pending requests, sticky errors, and the current
    // transaction described by its issue and response cycle numbers.
    logic [1:0]        ref_pend;
    logic [1:0]        ref_rw;
    logic [ADDR_W-1:0] ref_addr [2];
    logic [LINE_W-1:0] ref_data [2];
    logic [1:0]        ref_overrun;
    int                ref_last;
    int                ref_owner;
    bit                ref_active;
    int                t_issue;
    int                t_resp;
    logic [LINE_W-1:0] ref_rdata;
    logic              ref_issue_rw;
    logic [ADDR_W-1:0] ref_issue_addr;
    logic [LINE_W-1:0] ref_issue_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m_req_valid     (m_req_valid),
        .m_req_rw        (m_req_rw),
        .m_req_addr      (m_req_addr),
        .m_req_dataout   (m_req_dataout),
        .m_req_ready     (m_req_ready),
        .m_req_datain    (m_req_datain),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_datain  (mem_req_datain),
        .mem_req_ready   (mem_req_ready),
        .grant_id        (grant_id),
        .busy            (busy),
        .overrun_err     (overrun_err)
    );

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        ref_pend       = 2'b00;
        ref_rw         = 2'b00;
        ref_addr[0]    = '0;
        ref_addr[1]    = '0;
        ref_data[0]    = '0;
        ref_data[1]    = '0;
        ref_overrun    = 2'b00;
        ref_last       = 1;
        ref_owner      = 0;
        ref_active     = 1'b0;
        t_issue        = 0;
        t_resp         = 0;
        ref_rdata      = '0;
        ref_issue_rw   = 1'b0;
        ref_issue_addr = '0;
        ref_issue_data = '0;
    endtask

    // Advance the model over one edge; cyc is the number of the cycle just entered.
    task automatic model_edge();
        logic [1:0] cleared;
        cleared = 2'b00;
        if (!ref_active) begin
            if (ref_pend != 2'b00) begin
                if (ref_pend == 2'b11) ref_owner = 1 - ref_last;
                else                   ref_owner = ref_pend[1] ? 1 : 0;
                ref_active     = 1'b1;
                t_issue        = cyc;
                t_resp         = 0;
                ref_issue_rw   = ref_rw[ref_owner];
                ref_issue_addr = ref_addr[ref_owner];
                ref_issue_data = ref_data[ref_owner];
            end
        end else if (t_resp == 0) begin
            if (cyc - 1 > t_issue && mem_req_ready) begin
                t_resp    = cyc;
                ref_rdata = mem_req_datain;
            end
        end else begin
            cleared[ref_owner] = 1'b1;
            ref_last           = ref_owner;
            ref_active         = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (cleared[i]) ref_pend[i] = 1'b0;
            if (m_req_valid[i]) begin
                if (ref_pend[i]) begin
                    ref_overrun[i] = 1'b1;
                end else begin
                    ref_pend[i] = 1'b1;
                    ref_rw[i]   = m_req_rw[i];
                    ref_addr[i] = m_req_addr[i*ADDR_W +: ADDR_W];
                    ref_data[i] = m_req_dataout[i*LINE_W +: LINE_W];
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_ready;
        exp_ready = (ref_active && t_resp == cyc) ? ((ref_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        checkOutput("mem_req_valid",   128'(mem_req_valid),   128'(ref_active && t_issue == cyc));
        checkOutput("mem_req_rw",      128'(mem_req_rw),      128'(ref_issue_rw));
        checkOutput("mem_req_addr",    128'(mem_req_addr),    128'(ref_issue_addr));
        checkOutput("mem_req_dataout", mem_req_dataout,       ref_issue_data);
        checkOutput("m_req_ready",     128'(m_req_ready),     128'(exp_ready));
        checkOutput("m_req_datain",    m_req_datain,          ref_rdata);
        checkOutput("grant_id",        128'(grant_id),        128'(ref_owner));
        checkOutput("busy",            128'(busy),            128'(ref_active));
        checkOutput("overrun_err",     128'(overrun_err),     128'(ref_overrun));
    endtask

    // Drive the prepared inputs across one edge, update the model, check, then drop the pulses.
    task automatic applyStimulus();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all();
        m_req_valid   = 2'b00;
        mem_req_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus();
        rst     = 1'b0;
        mem_cnt = 0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
        m_req_valid[i]                    = 1'b1;
        m_req_rw[i]                       = rw;
        m_req_addr[i*ADDR_W +: ADDR_W]    = addr;
        m_req_dataout[i*LINE_W +: LINE_W] = data;
    endtask

    // Mode 0: legal random traffic, 1: unrestricted traffic, 2: round-robin pattern.
    task automatic cycle_auto(input int mode, input int stray_pct);
        bit in_resp;
        bit ok;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_req_ready  = 1'b1;
                mem_req_datain = rand_line();
            end
        end else if ($urandom_range(0, 99) < stray_pct) begin
            mem_req_ready  = 1'b1;
            mem_req_datain = rand_line();
        end
        for (int i = 0; i < 2; i++) begin
            in_resp = ref_active && t_resp == cyc && ref_owner == i;
            if (mode == 0)      ok = (!ref_pend[i] || in_resp) && ($urandom_range(0, 2) == 0);
            else if (mode == 1) ok = ($urandom_range(0, 4) == 0);
            else if (i == 1)    ok = !ref_pend[i] || in_resp;
            else                ok = in_resp;
            if (ok) set_req(i, 1'($urandom_range(0, 1)), $urandom, rand_line());
        end
        applyStimulus();
        if (ref_active && t_issue == cyc) begin
            mem_cnt = $urandom_range(1, 4);
            if (mode == 2) begin
                checkOutput("rr_grant", 128'(grant_id), 128'(rr_exp));
                rr_exp = ~rr_exp;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        m_req_valid    = 2'b00;
        m_req_rw       = 2'b00;
        m_req_addr     = '0;
        m_req_dataout  = '0;
        mem_req_datain = '0;
        mem_req_ready  = 1'b0;
        model_reset();

        $display("[TB] reset");
        do_reset();
        do_reset();

        $display("[TB] single read");
        set_req(0, 1'b0, 32'h0000_1230, rand_line());
        applyStimulus();
        applyStimulus();
        checkOutput("sr_issue", 128'(mem_req_valid), 128'(1));
        checkOutput("sr_addr",  128'(mem_req_addr),  128'(32'h1230));
        checkOutput("sr_rw",    128'(mem_req_rw),    128'(0));
        applyStimulus();
        applyStimulus();
        mem_req_ready  = 1'b1;
        mem_req_datain = {16{8'hA5}};
        applyStimulus();
        checkOutput("sr_ready", 128'(m_req_ready), 128'(2'b01));
        checkOutput("sr_data",  m_req_datain,      {16{8'hA5}});
        checkOutput("sr_grant", 128'(grant_id),    128'(0));
        applyStimulus();

        $display("[TB] simultaneous requests");
        do_reset();
        set_req(0, 1'b0, 32'h0000_4000, rand_line());
        set_req(1, 1'b1, 32'h0000_8000, {16{8'h11}});
        applyStimulus();
        applyStimulus();
        checkOutput("sim_first_grant", 128'(grant_id), 128'(0));
        applyStimulus();
        mem_req_ready  = 1'b1;
        mem_req_datain = rand_line();
        applyStimulus();
        checkOutput("sim_resp0", 128'(m_req_ready), 128'(2'b01));
        applyStimulus();
        checkOutput("sim_gap_busy",  128'(busy),          128'(0));
        checkOutput("sim_gap_valid", 128'(mem_req_valid), 128'(0));
        applyStimulus();
        checkOutput("sim_issue1", 128'(mem_req_valid),   128'(1));
        checkOutput("sim_grant1", 128'(grant_id),        128'(1));
        checkOutput("sim_rw1",    128'(mem_req_rw),      128'(1));
        checkOutput("sim_data1",  mem_req_dataout,       {16{8'h11}});
        applyStimulus();
        mem_req_ready = 1'b1;
        applyStimulus();
        checkOutput("sim_resp1", 128'(m_req_ready), 128'(2'b10));
        applyStimulus();

        $display("[TB] round robin");
        do_reset();
        rr_exp = 1'b0;
        set_req(0, 1'b0, 32'h0000_0040, rand_line());
        for (int n = 0; n < 45; n++) cycle_auto(2, 0);
        checkOutput("rr_overrun", 128'(overrun_err), 128'(0));

        $display("[TB] overrun");
        do_reset();
        set_req(1, 1'b0, 32'h0000_2000, rand_line());
        applyStimulus();
        applyStimulus();
        applyStimulus();
        set_req(1, 1'b1, 32'h0000_3000, rand_line());
        applyStimulus();
        checkOutput("ovr_flag", 128'(overrun_err), 128'(2'b10));
        set_req(1, 1'b0, 32'h0000_3400, rand_line());
        applyStimulus();
        mem_req_ready = 1'b1;
        applyStimulus();
        checkOutput("ovr_resp", 128'(m_req_ready), 128'(2'b10));
        applyStimulus();
        checkOutput("ovr_sticky", 128'(overrun_err), 128'(2'b10));
        applyStimulus();
        checkOutput("ovr_no_second", 128'(mem_req_valid), 128'(0));
        checkOutput("ovr_idle",      128'(busy),          128'(0));

        $display("[TB] stray ready and reset mid-wait");
        mem_req_ready = 1'b1;
        applyStimulus();
        checkOutput("stray_busy",  128'(busy),        128'(0));
        checkOutput("stray_ready", 128'(m_req_ready), 128'(0));
        set_req(0, 1'b1, 32'h0000_5550, rand_line());
        applyStimulus();
        applyStimulus();
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy",    128'(busy),         128'(0));
        checkOutput("arst_addr",    128'(mem_req_addr), 128'(0));
        checkOutput("arst_overrun", 128'(overrun_err),  128'(0));
        model_reset();
        compare_all();
        applyStimulus();
        rst = 1'b0;
        mem_req_ready = 1'b1;
        applyStimulus();
        checkOutput("post_rst_ready", 128'(m_req_ready), 128'(0));
        applyStimulus();
        applyStimulus();
        checkOutput("post_rst_no_issue", 128'(mem_req_valid), 128'(0));

        $display("[TB] random legal traffic");
        do_reset();
        for (int n = 0; n < 800; n++) cycle_auto(0, 5);

        $display("[TB] random unrestricted traffic");
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if (n == 250) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                applyStimulus();
                rst     = 1'b0;
                mem_cnt = 0;
            end
            cycle_auto(1, 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares one main-memory request port between two cache controllers, e.g. an instruction cache and a data cache. Each master issues a one-cycle request pulse and later waits for a one-cycle completion pulse. The arbiter captures requests, serializes them round-robin onto the memory port with the same pulse protocol, and routes completion and read data back to the owning master. It sits between the cache controllers' memory ports and the main-memory model.

## Interface
Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, cache line width for read and write data.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- m_req_valid  in  2  per-master request pulse; bit i = master i.
- m_req_rw  in  2  1 = write, 0 = read.
- m_req_addr  in  2*ADDR_W  master i address in slice [i*ADDR_W +: ADDR_W].
- m_req_dataout  in  2*LINE_W  master i write line.
- m_req_ready  out  2  per-master completion pulse.
- m_req_datain  out  LINE_W  read line, shared bus; valid only while m_req_ready[i]=1.
- mem_req_valid  out  1  memory request pulse.
- mem_req_rw  out  1  memory read/write.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_dataout  out  LINE_W  memory write line.
- mem_req_datain  in  LINE_W  memory read line; sampled when mem_req_ready=1.
- mem_req_ready  in  1  memory completion pulse.
- grant_id  out  1  master owning the current or most recent transaction.
- busy  out  1  1 in any state except IDLE.
- overrun_err  out  2  sticky per-master protocol-violation flag.

## Operation
- **Capture.** A pulse on m_req_valid[i] latches rw, addr and data into buffer i and sets pend[i] on the next edge.
  - If pend[i] is already set and not being cleared that cycle, the new pulse is dropped and overrun_err[i] is set (sticky until rst).
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE.**
  - If any pend bit is set, pick the winner and go to ISSUE.
  - If only one pend bit is set, that master wins.
  - If both are set, the master that is not last_grant wins.
  - The winner is written to grant_id.
- **ISSUE.** mem_req_valid=1 for exactly one cycle, with rw, addr and data from buffer[grant_id]. Next state is WAIT.
- **WAIT.** mem_req_valid=0. On mem_req_ready=1, capture mem_req_datain into rdata_q and go to RESP.
- **RESP.**
  - m_req_ready[grant_id]=1 for one cycle, with m_req_datain=rdata_q.
  - On leaving RESP: clear pend[grant_id], set last_grant=grant_id, go to IDLE.
  - For writes, m_req_datain carries whatever the memory returned; masters ignore it.
- **Pend set and clear in the same cycle:** if a new m_req_valid[grant_id] pulse arrives during the RESP cycle, the set wins. It is a legal back-to-back request and does not raise overrun.
- **Stray completions:** mem_req_ready outside WAIT is ignored. No state change, no error.
- **Output hold:** mem_req_addr, mem_req_rw and mem_req_dataout hold their last values outside ISSUE. m_req_datain holds rdata_q.
- **Registered outputs:** all outputs are driven directly from flops; there is no combinational path from input to output.

## Timing
- **Reset values:** every output is 0. State=IDLE, pend=0, last_grant=1 (so master 0 wins the first tie), rdata_q=0, buffers=0.
- **Reset mid-transaction:** any transaction in progress is abandoned with no m_req_ready pulse. The memory-side transaction is the environment's responsibility.
- **Cycle-level sequence** for a pulse at edge-sampled cycle T on an idle arbiter:
  - T+1: pend set, FSM in IDLE.
  - T+2: ISSUE, mem_req_valid=1.
  - T+3 onward: WAIT.
  - If mem_req_ready is sampled in cycle W, m_req_ready=1 in cycle W+1.
  - IDLE is reached at W+2.
  - Minimum request-to-ready latency: 4 cycles when memory answers in the first WAIT cycle.
- **Back-to-back grants:** when a second request is already pending, there is one IDLE cycle between RESP and the next ISSUE. Throughput is one transaction per 4 cycles plus memory latency.
- **Latency bound:** no timeout. A master waits at most one foreign transaction plus its own.

## Structure
- **Package mem_arb_pkg** holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - default ADDR_W and LINE_W localparams;
  - struct req_t {rw, addr, data}.
- **Sub-module mem_arb_req_buf**, instantiated twice, one per master. It holds the request capture register, the pend flag with set-over-clear priority, and overrun detection.
- **Top level** holds the FSM, the round-robin pointer and the memory/response muxing.

## Test plan
- **Single read:** m0 reads addr 0x0000_1230; memory answers 2 cycles after mem_req_valid with 0xA5A5…A5 (128-bit) → mem_req_addr=0x1230, rw=0; m_req_ready=2'b01 one cycle later with that line; grant_id=0.
- **Simultaneous requests after reset:** m0 and m1 pulse in the same cycle → m0 is served first, then m1. Exactly one IDLE cycle separates RESP(m0) from ISSUE(m1). m1 write data 0x1111…11 appears on mem_req_dataout with rw=1.
- **Round-robin fairness:** m1 issues 4 back-to-back requests while m0 re-requests at each of its own RESP → grants alternate 0,1,0,1; overrun_err stays 0.
- **Overrun:** m1 pulses twice while its first request is still in WAIT → overrun_err=2'b10 and stays set; only one m1 transaction reaches memory.
- **Stray ready and reset mid-WAIT:** mem_req_ready pulse in IDLE → no change. Then assert rst during WAIT → all outputs 0 and pend cleared. A subsequent mem_req_ready produces no m_req_ready.
